sayuru_port_arbiter: RTL and testbench

- Shares one core-memory-protocol slave (the sayuru direct-mapped cache input port) between two requesters: port 0 (instruction fetch) and port 1 (data LSU).
- Round-robin arbitration on req/gnt; a per-grant owner-ID FIFO routes each in-order rvalid/rdata back to the port that issued it.
- Sits between the core and the cache wrapper; the downstream side connects directly to the cache's in_data_* ports.

---
 rtl/sayuru_arb_pkg.sv | 14 +
 rtl/sayuru_arb_id_fifo.sv | 64 ++++++
 rtl/sayuru_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sayuru_port_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sayuru_arb_pkg.sv
// Shared types for the sayuru two-port round-robin arbiter.
package sayuru_arb_pkg;

  typedef enum logic {
    ARB_IDLE     = 1'b0,
    ARB_WAIT_GNT = 1'b1
  } arb_state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT_INSTR = 1'b0;
  localparam port_id_t PORT_DATA  = 1'b1;

endpackage

// File: rtl/sayuru_arb_id_fifo.sv
// Owner-ID FIFO: records which port received each grant so in-order responses can be routed back.
module sayuru_arb_id_fifo
  import sayuru_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  port_id_t         push_id,
  input  logic             pop,
  output port_id_t         head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  port_id_t               mem_q [DEPTH];
  port_id_t               mem_d [DEPTH];
  logic     [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic     [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic     [CNT_W-1:0]   count_q, count_d;
  logic                   do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: PORT_INSTR};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sayuru_port_arbiter.sv
// Round-robin arbiter sharing one cache port between instruction fetch (port 0) and LSU (port 1).
// Define SAYURU_ARB_STATS_EN to add per-port 32-bit grant counters.
module sayuru_port_arbiter
  import sayuru_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    p0_req_i,
  output logic                    p0_gnt_o,
  output logic                    p0_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,
  input  logic                    p1_req_i,
  output logic                    p1_gnt_o,
  output logic                    p1_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,
  output logic                    out_req_o,
  input  logic                    out_gnt_i,
  input  logic                    out_rvalid_i,
  output logic [ADDR_WIDTH-1:0]   out_addr_o,
  output logic                    out_we_o,
  output logic [DATA_WIDTH/8-1:0] out_be_o,
  output logic [DATA_WIDTH-1:0]   out_wdata_o,
  input  logic [DATA_WIDTH-1:0]   out_rdata_i,
  output logic                    busy_o,
  output logic                    err_o
`ifdef SAYURU_ARB_STATS_EN
  ,
  output logic [31:0]             p0_grant_count_o,
  output logic [31:0]             p1_grant_count_o
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_t       state_q, state_d;
  port_id_t         lock_sel_q, lock_sel_d;
  port_id_t         rr_ptr_q, rr_ptr_d;
  logic             err_q, err_d;
  port_id_t         sel;
  logic             sel_req;
  logic             accept;
  logic             fifo_pop;
  logic             fifo_full, fifo_empty;
  port_id_t         fifo_head;
  logic [CNT_W-1:0] fifo_count;

  // Arbitration, FSM next state and round-robin pointer update.
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    rr_ptr_d   = rr_ptr_q;
    err_d      = err_q;
    sel        = PORT_INSTR;

    if (state_q == ARB_WAIT_GNT) begin
      sel = lock_sel_q;
    end else if (p0_req_i && p1_req_i) begin
      sel = rr_ptr_q;
    end else if (p1_req_i) begin
      sel = PORT_DATA;
    end

    sel_req   = (sel == PORT_DATA) ? p1_req_i : p0_req_i;
    out_req_o = sel_req & ~fifo_full & ~rst;
    accept    = out_req_o & out_gnt_i;
    fifo_pop  = out_rvalid_i & ~fifo_empty & ~rst;

    if (state_q == ARB_IDLE) begin
      if (out_req_o && !out_gnt_i) begin
        state_d    = ARB_WAIT_GNT;
        lock_sel_d = sel;
      end
    end else if (out_gnt_i) begin
      state_d = ARB_IDLE;
    end

    if (accept) begin
      rr_ptr_d = port_id_t'(~sel);
    end
    if (out_rvalid_i && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  assign p0_gnt_o    = accept & (sel == PORT_INSTR);
  assign p1_gnt_o    = accept & (sel == PORT_DATA);
  assign out_addr_o  = (sel == PORT_DATA) ? p1_addr_i  : p0_addr_i;
  assign out_we_o    = (sel == PORT_DATA) ? p1_we_i    : p0_we_i;
  assign out_be_o    = (sel == PORT_DATA) ? p1_be_i    : p0_be_i;
  assign out_wdata_o = (sel == PORT_DATA) ? p1_wdata_i : p0_wdata_i;

  assign p0_rvalid_o = fifo_pop & (fifo_head == PORT_INSTR);
  assign p1_rvalid_o = fifo_pop & (fifo_head == PORT_DATA);
  assign p0_rdata_o  = out_rdata_i;
  assign p1_rdata_o  = out_rdata_i;
  assign busy_o      = (fifo_count != '0);
  assign err_o       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      lock_sel_q <= PORT_INSTR;
      rr_ptr_q   <= PORT_INSTR;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      rr_ptr_q   <= rr_ptr_d;
      err_q      <= err_d;
    end
  end

  sayuru_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .push_id (sel),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef SAYURU_ARB_STATS_EN
  logic [31:0] p0_cnt_q, p0_cnt_d;
  logic [31:0] p1_cnt_q, p1_cnt_d;

  // Grant counters wrap modulo 2^32.
  always_comb begin
    p0_cnt_d = p0_cnt_q;
    p1_cnt_d = p1_cnt_q;
    if (p0_gnt_o) p0_cnt_d = p0_cnt_q + 32'd1;
    if (p1_gnt_o) p1_cnt_d = p1_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p0_cnt_q <= '0;
      p1_cnt_q <= '0;
    end else begin
      p0_cnt_q <= p0_cnt_d;
      p1_cnt_q <= p1_cnt_d;
    end
  end

  assign p0_grant_count_o = p0_cnt_q;
  assign p1_grant_count_o = p1_cnt_q;
`endif

endmodule

// File: tb/tb_sayuru_port_arbiter.sv
// Self-checking bench for sayuru_port_arbiter: directed scenarios plus a randomized run against a queue model.
// Define SAYURU_ARB_STATS_EN to also exercise the grant counters.
module tb_sayuru_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 4;

  logic          clk, rst;
  logic          p0_req_i, p0_gnt_o, p0_rvalid_o, p0_we_i;
  logic [AW-1:0] p0_addr_i;
  logic [BW-1:0] p0_be_i;
  logic [DW-1:0] p0_wdata_i, p0_rdata_o;
  logic          p1_req_i, p1_gnt_o, p1_rvalid_o, p1_we_i;
  logic [AW-1:0] p1_addr_i;
  logic [BW-1:0] p1_be_i;
  logic [DW-1:0] p1_wdata_i, p1_rdata_o;
  logic          out_req_o, out_gnt_i, out_rvalid_i, out_we_o;
  logic [AW-1:0] out_addr_o;
  logic [BW-1:0] out_be_o;
  logic [DW-1:0] out_wdata_o, out_rdata_i;
  logic          busy_o, err_o;
`ifdef SAYURU_ARB_STATS_EN
  logic [31:0]   p0_grant_count_o, p1_grant_count_o;
`endif

  int vectors;
  int miscompares;

  sayuru_port_arbiter #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .p0_req_i     (p0_req_i),
    .p0_gnt_o     (p0_gnt_o),
    .p0_rvalid_o  (p0_rvalid_o),
    .p0_addr_i    (p0_addr_i),
    .p0_we_i      (p0_we_i),
    .p0_be_i      (p0_be_i),
    .p0_wdata_i   (p0_wdata_i),
    .p0_rdata_o   (p0_rdata_o),
    .p1_req_i     (p1_req_i),
    .p1_gnt_o     (p1_gnt_o),
    .p1_rvalid_o  (p1_rvalid_o),
    .p1_addr_i    (p1_addr_i),
    .p1_we_i      (p1_we_i),
    .p1_be_i      (p1_be_i),
    .p1_wdata_i   (p1_wdata_i),
    .p1_rdata_o   (p1_rdata_o),
    .out_req_o    (out_req_o),
    .out_gnt_i    (out_gnt_i),
    .out_rvalid_i (out_rvalid_i),
    .out_addr_o   (out_addr_o),
    .out_we_o     (out_we_o),
    .out_be_o     (out_be_o),
    .out_wdata_o  (out_wdata_o),
    .out_rdata_i  (out_rdata_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
`ifdef SAYURU_ARB_STATS_EN
    ,
    .p0_grant_count_o (p0_grant_count_o),
    .p1_grant_count_o (p1_grant_count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the falling edge; checks happen 1ns later, well before the rising edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    p0_req_i = 0; p0_addr_i = '0; p0_we_i = 0; p0_be_i = '0; p0_wdata_i = '0;
    p1_req_i = 0; p1_addr_i = '0; p1_we_i = 0; p1_be_i = '0; p1_wdata_i = '0;
    out_gnt_i = 0; out_rvalid_i = 0; out_rdata_i = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1;
    p0_req_i = 1; p1_req_i = 1; out_gnt_i = 1; out_rvalid_i = 1;
    tick();
    #1;
    vectors++; if (p0_gnt_o !== 1'b0) begin miscompares++; $display("FAIL reset_p0_gnt got=%0h exp=0", p0_gnt_o); end
    vectors++; if (p1_gnt_o !== 1'b0) begin miscompares++; $display("FAIL reset_p1_gnt got=%0h exp=0", p1_gnt_o); end
    vectors++; if (out_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_out_req got=%0h exp=0", out_req_o); end
    vectors++; if ({p0_rvalid_o, p1_rvalid_o} !== 2'b00) begin miscompares++; $display("FAIL reset_rvalid got=%b exp=00", {p0_rvalid_o, p1_rvalid_o}); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%0h exp=0", busy_o); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%0h exp=0", err_o); end
    idle_inputs();
    rst = 0;
    tick();
    #1;
    vectors++; if ({out_req_o, busy_o, err_o} !== 3'b000) begin miscompares++; $display("FAIL post_reset_idle got=%b exp=000", {out_req_o, busy_o, err_o}); end
  endtask

  task automatic test_single_read;
    do_reset();
    p0_req_i = 1; p0_addr_i = 16'h0010; p0_be_i = 4'hF; out_gnt_i = 1;
    #1;
    vectors++; if (p0_gnt_o !== 1'b1) begin miscompares++; $display("FAIL single_p0_gnt got=%0h exp=1", p0_gnt_o); end
    vectors++; if (p1_gnt_o !== 1'b0) begin miscompares++; $display("FAIL single_p1_gnt got=%0h exp=0", p1_gnt_o); end
    vectors++; if (out_addr_o !== 16'h0010) begin miscompares++; $display("FAIL single_addr got=%h exp=0010", out_addr_o); end
    tick();
    idle_inputs();
    #1;
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL single_busy got=%0h exp=1", busy_o); end
    tick();
    out_rvalid_i = 1; out_rdata_i = 32'hDEADBEEF;
    #1;
    vectors++; if ({p0_rvalid_o, p1_rvalid_o} !== 2'b10) begin miscompares++; $display("FAIL single_rvalid got=%b exp=10", {p0_rvalid_o, p1_rvalid_o}); end
    vectors++; if (p0_rdata_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_rdata got=%h exp=deadbeef", p0_rdata_o); end
    tick();
    idle_inputs();
    #1;
    vectors++; if ({busy_o, err_o} !== 2'b00) begin miscompares++; $display("FAIL single_drained got=%b exp=00", {busy_o, err_o}); end
  endtask

  task automatic test_alternate;
    logic exp_port;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      p0_req_i = 1; p0_addr_i = 16'h0100; p1_req_i = 1; p1_addr_i = 16'h0200; out_gnt_i = 1;
      exp_port = 1'(i % 2);
      #1;
      vectors++; if ({p0_gnt_o, p1_gnt_o} !== {~exp_port, exp_port}) begin miscompares++; $display("FAIL alt_gnt[%0d] got=%b exp=%b", i, {p0_gnt_o, p1_gnt_o}, {~exp_port, exp_port}); end
      vectors++; if (out_addr_o !== (exp_port ? 16'h0200 : 16'h0100)) begin miscompares++; $display("FAIL alt_addr[%0d] got=%h", i, out_addr_o); end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      out_rvalid_i = 1;
      exp_port = 1'(i % 2);
      #1;
      vectors++; if ({p0_rvalid_o, p1_rvalid_o} !== {~exp_port, exp_port}) begin miscompares++; $display("FAIL alt_rvalid[%0d] got=%b exp=%b", i, {p0_rvalid_o, p1_rvalid_o}, {~exp_port, exp_port}); end
      tick();
    end
    idle_inputs();
    #1;
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL alt_busy got=%0h exp=0", busy_o); end
  endtask

  task automatic test_lock;
    do_reset();
    p1_req_i = 1; p1_addr_i = 16'h0300; p0_addr_i = 16'h0040; out_gnt_i = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) p0_req_i = 1;
      #1;
      vectors++; if (out_addr_o !== 16'h0300) begin miscompares++; $display("FAIL lock_addr[%0d] got=%h exp=0300", i, out_addr_o); end
      vectors++; if ({out_req_o, p0_gnt_o, p1_gnt_o} !== 3'b100) begin miscompares++; $display("FAIL lock_req[%0d] got=%b exp=100", i, {out_req_o, p0_gnt_o, p1_gnt_o}); end
      tick();
    end
    out_gnt_i = 1;
    #1;
    vectors++; if ({p0_gnt_o, p1_gnt_o} !== 2'b01) begin miscompares++; $display("FAIL lock_first_gnt got=%b exp=01", {p0_gnt_o, p1_gnt_o}); end
    tick();
    p1_req_i = 0;
    #1;
    vectors++; if ({p0_gnt_o, p1_gnt_o} !== 2'b10 || out_addr_o !== 16'h0040) begin miscompares++; $display("FAIL lock_second_gnt got=%b/%h exp=10/0040", {p0_gnt_o, p1_gnt_o}, out_addr_o); end
    tick();
    idle_inputs();
    out_rvalid_i = 1;
    #1;
    vectors++; if ({p0_rvalid_o, p1_rvalid_o} !== 2'b01) begin miscompares++; $display("FAIL lock_rv0 got=%b exp=01", {p0_rvalid_o, p1_rvalid_o}); end
    tick();
    #1;
    vectors++; if ({p0_rvalid_o, p1_rvalid_o} !== 2'b10) begin miscompares++; $display("FAIL lock_rv1 got=%b exp=10", {p0_rvalid_o, p1_rvalid_o}); end
    tick();
    idle_inputs();
  endtask

  task automatic test_full;
    do_reset();
    p1_req_i = 1; out_gnt_i = 1;
    for (int i = 0; i < MO; i++) begin
      p1_addr_i = AW'(16'h0400 + i);
      #1;
      vectors++; if (p1_gnt_o !== 1'b1) begin miscompares++; $display("FAIL full_fill[%0d] got=%0h exp=1", i, p1_gnt_o); end
      tick();
    end
    p1_req_i = 0; p0_req_i = 1; p0_addr_i = 16'h0050;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++; if ({out_req_o, p0_gnt_o, busy_o} !== 3'b001) begin miscompares++; $display("FAIL full_block[%0d] got=%b exp=001", i, {out_req_o, p0_gnt_o, busy_o}); end
      tick();
    end
    out_rvalid_i = 1;
    #1;
    vectors++; if ({out_req_o, p0_gnt_o, p1_rvalid_o} !== 3'b001) begin miscompares++; $display("FAIL full_pop_cycle got=%b exp=001", {out_req_o, p0_gnt_o, p1_rvalid_o}); end
    tick();
    out_rvalid_i = 0;
    #1;
    vectors++; if ({out_req_o, p0_gnt_o} !== 2'b11) begin miscompares++; $display("FAIL full_after_pop got=%b exp=11", {out_req_o, p0_gnt_o}); end
    tick();
    idle_inputs();
    for (int i = 0; i < MO; i++) begin
      out_rvalid_i = 1;
      #1;
      vectors++; if ({p0_rvalid_o, p1_rvalid_o} !== ((i == MO - 1) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL full_drain[%0d] got=%b", i, {p0_rvalid_o, p1_rvalid_o}); end
      tick();
    end
    idle_inputs();
    #1;
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL full_busy got=%0h exp=0", busy_o); end
  endtask

  task automatic test_err;
    do_reset();
    out_rvalid_i = 1;
    #1;
    vectors++; if ({p0_rvalid_o, p1_rvalid_o} !== 2'b00) begin miscompares++; $display("FAIL err_rvalid got=%b exp=00", {p0_rvalid_o, p1_rvalid_o}); end
    tick();
    out_rvalid_i = 0;
    #1;
    vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL err_set got=%0h exp=1", err_o); end
    tick(); tick(); tick();
    #1;
    vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL err_sticky got=%0h exp=1", err_o); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL err_clear got=%0h exp=0", err_o); end
  endtask

  // Model: a queue of owner IDs, a favoured-port bit and an optional locked port.
  task automatic test_random;
    bit            q[$];
    bit            rr_m, locked_m, lock_m, err_m, e_sel, e_req, e_rv0, e_rv1;
    bit            pend[2];
    logic [AW-1:0] paddr[2];
    logic          pwe[2];
    logic [BW-1:0] pbe[2];
    logic [DW-1:0] pwd[2];
    do_reset();
    rr_m = 0; locked_m = 0; lock_m = 0; err_m = 0;
    pend[0] = 0; pend[1] = 0;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p] = 1; paddr[p] = AW'($urandom); pwe[p] = 1'($urandom);
          pbe[p] = BW'($urandom); pwd[p] = $urandom;
        end
      end
      p0_req_i = pend[0]; p0_addr_i = paddr[0]; p0_we_i = pwe[0]; p0_be_i = pbe[0]; p0_wdata_i = pwd[0];
      p1_req_i = pend[1]; p1_addr_i = paddr[1]; p1_we_i = pwe[1]; p1_be_i = pbe[1]; p1_wdata_i = pwd[1];
      out_gnt_i    = 1'($urandom_range(0, 1));
      out_rvalid_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      out_rdata_i  = $urandom;
      e_sel = locked_m ? lock_m : ((pend[0] && pend[1]) ? rr_m : pend[1]);
      e_req = pend[e_sel] && (q.size() < MO);
      e_rv0 = 0; e_rv1 = 0;
      if (out_rvalid_i && q.size() > 0) begin
        e_rv0 = !q[0]; e_rv1 = q[0];
      end
      #1;
      vectors++; if (out_req_o !== e_req) begin miscompares++; $display("FAIL rnd_out_req[%0d] got=%0h exp=%0h", n, out_req_o, e_req); end
      vectors++; if ({p0_gnt_o, p1_gnt_o} !== {out_gnt_i && e_req && !e_sel, out_gnt_i && e_req && e_sel}) begin miscompares++; $display("FAIL rnd_gnt[%0d] got=%b sel=%0d req=%0d", n, {p0_gnt_o, p1_gnt_o}, e_sel, e_req); end
      vectors++; if ({p0_rvalid_o, p1_rvalid_o} !== {e_rv0, e_rv1}) begin miscompares++; $display("FAIL rnd_rvalid[%0d] got=%b exp=%b", n, {p0_rvalid_o, p1_rvalid_o}, {e_rv0, e_rv1}); end
      vectors++; if ({busy_o, err_o} !== {q.size() != 0, err_m}) begin miscompares++; $display("FAIL rnd_status[%0d] got=%b exp=%b", n, {busy_o, err_o}, {q.size() != 0, err_m}); end
      vectors++; if ({p0_rdata_o, p1_rdata_o} !== {out_rdata_i, out_rdata_i}) begin miscompares++; $display("FAIL rnd_rdata[%0d] got=%h/%h exp=%h", n, p0_rdata_o, p1_rdata_o, out_rdata_i); end
      if (e_req) begin
        vectors++; if ({out_addr_o, out_we_o, out_be_o, out_wdata_o} !== {paddr[e_sel], pwe[e_sel], pbe[e_sel], pwd[e_sel]}) begin miscompares++; $display("FAIL rnd_fields[%0d] got=%h exp=%h", n, {out_addr_o, out_we_o, out_be_o, out_wdata_o}, {paddr[e_sel], pwe[e_sel], pbe[e_sel], pwd[e_sel]}); end
      end
      if (out_rvalid_i) begin
        if (q.size() > 0) void'(q.pop_front());
        else err_m = 1;
      end
      if (e_req && out_gnt_i) begin
        q.push_back(e_sel);
        rr_m = !e_sel;
        pend[e_sel] = 0;
      end
      if (!locked_m && e_req && !out_gnt_i) begin
        locked_m = 1; lock_m = e_sel;
      end else if (locked_m && out_gnt_i) begin
        locked_m = 0;
      end
      tick();
    end
    idle_inputs();
  endtask

`ifdef SAYURU_ARB_STATS_EN
  task automatic test_stats;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      p0_req_i = (i < 3); p1_req_i = (i >= 3); out_gnt_i = 1; out_rvalid_i = (i > 0);
      #1;
      vectors++; if ({p0_gnt_o, p1_gnt_o} !== {i < 3, i >= 3}) begin miscompares++; $display("FAIL stats_gnt[%0d] got=%b", i, {p0_gnt_o, p1_gnt_o}); end
      tick();
    end
    idle_inputs();
    out_rvalid_i = 1;
    tick();
    idle_inputs();
    #1;
    vectors++; if (p0_grant_count_o !== 32'd3) begin miscompares++; $display("FAIL stats_p0 got=%0d exp=3", p0_grant_count_o); end
    vectors++; if (p1_grant_count_o !== 32'd5) begin miscompares++; $display("FAIL stats_p1 got=%0d exp=5", p1_grant_count_o); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    vectors++; if ({p0_grant_count_o, p1_grant_count_o} !== 64'd0) begin miscompares++; $display("FAIL stats_clear got=%0d/%0d exp=0/0", p0_grant_count_o, p1_grant_count_o); end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_alternate();
    test_lock();
    test_full();
    test_err();
    test_random();
`ifdef SAYURU_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
